// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC sequencer: FSM state encoding and
// the alignment-bit count derived from the instruction size.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    // Number of PC low bits that are always zero for a given instruction size.
    function automatic int align_bits(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: exception beats branch, the chosen target is
// aligned to the instruction size and a misaligned request is flagged.
module pc_redirect_arb
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ALIGN = 2
) (
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_vector,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic             sel_valid,
    output logic [WIDTH-1:0] sel_target,
    output logic             sel_misalign
);

    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << ALIGN) - WIDTH'(1);

    logic [WIDTH-1:0] raw_target;

    assign sel_valid    = exc_valid | br_valid;
    assign raw_target   = exc_valid ? exc_vector : br_target;
    assign sel_target   = raw_target & ~LOW_MASK;
    // Only meaningful when sel_valid; the top qualifies it before latching.
    assign sel_misalign = |(raw_target & LOW_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: valid/ready advance, prioritised redirects, stall and halt.
// Optional saturating redirect counter enabled by PC_SEQ_REDIRECT_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INSTR_BYTES  = 4,
    parameter int               READ_AHEAD   = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             fetch_ready,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_vector,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] pc_read,
    output logic             redirect_taken,
    output logic             misalign_err,
`ifdef PC_SEQ_REDIRECT_CNT_EN
    output logic [15:0]      redirect_cnt,
`endif
    output logic [1:0]       fsm_state
);

    localparam int ALIGN = align_bits(INSTR_BYTES);

    pc_state_e        state, state_nxt;
    logic [WIDTH-1:0] pc_nxt;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_target;
    logic             sel_misalign;
    logic             advance;

    pc_redirect_arb #(
        .WIDTH (WIDTH),
        .ALIGN (ALIGN)
    ) u_arb (
        .exc_valid    (exc_valid),
        .exc_vector   (exc_vector),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .sel_valid    (sel_valid),
        .sel_target   (sel_target),
        .sel_misalign (sel_misalign)
    );

    // Adds wrap modulo 2^WIDTH by construction.
    assign pc_plus = pc + WIDTH'(INSTR_BYTES);
    assign pc_read = pc + WIDTH'(READ_AHEAD * INSTR_BYTES);

    assign advance = fetch_valid & fetch_ready & ~stall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: give every combinationally assigned signal a default first so no
    // path leaves it unassigned and a latch is inferred.
    always_comb begin
        state_nxt = state;
        if (sel_valid) begin
            state_nxt = RUN;
        end else if (!stall) begin
            unique case (state)
                BOOT:    state_nxt = RUN;
                RUN:     state_nxt = halt ? HALTED : RUN;
                HALTED:  state_nxt = halt ? HALTED : RUN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_comb begin
        fetch_valid = (state == RUN);
        fsm_state   = state;
    end

    always_comb begin
        pc_nxt = pc;
        if (sel_valid) begin
            pc_nxt = sel_target;
        end else if (advance) begin
            pc_nxt = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_VECTOR;
            redirect_taken <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            redirect_taken <= sel_valid;
            misalign_err   <= misalign_err | (sel_valid & sel_misalign);
        end
    end

`ifdef PC_SEQ_REDIRECT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else if (sel_valid && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_vector = '0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [31:0] pc_plus;
    logic [31:0] pc_read;
    logic        redirect_taken;
    logic        misalign_err;
    logic [1:0]  fsm_state;
`ifdef PC_SEQ_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    pc_sequencer #(
        .WIDTH        (32),
        .INSTR_BYTES  (4),
        .READ_AHEAD   (2),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .halt           (halt),
        .fetch_ready    (fetch_ready),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .exc_valid      (exc_valid),
        .exc_vector     (exc_vector),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .pc_plus        (pc_plus),
        .pc_read        (pc_read),
        .redirect_taken (redirect_taken),
        .misalign_err   (misalign_err),
`ifdef PC_SEQ_REDIRECT_CNT_EN
        .redirect_cnt   (redirect_cnt),
`endif
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_rt;
    bit          m_mis;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_mode = 0;
        m_rt   = 0;
        m_mis  = 0;
        m_cnt  = 0;
    endtask

    // One clock of the specified behaviour, using the inputs currently applied.
    task automatic model_step();
        logic [31:0] tgt;
        if (exc_valid || br_valid) begin
            tgt    = exc_valid ? exc_vector : br_target;
            m_pc   = {tgt[31:2], 2'b00};
            m_mis  = m_mis || (tgt % 4 != 0);
            m_mode = 1;
            m_rt   = 1;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_rt = 0;
            if (!stall) begin
                if (m_mode == 1 && fetch_ready) m_pc = m_pc + 32'd4;
                if (m_mode == 0)      m_mode = 1;
                else                  m_mode = halt ? 2 : 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       pc,                          m_pc);
        check({tag, ".valid"},    32'(fetch_valid),            32'(m_mode == 1));
        check({tag, ".pc_plus"},  pc_plus,                     m_pc + 32'd4);
        check({tag, ".pc_read"},  pc_read,                     m_pc + 32'd8);
        check({tag, ".redir"},    32'(redirect_taken),         32'(m_rt));
        check({tag, ".misalign"}, 32'(misalign_err),           32'(m_mis));
        check({tag, ".state"},    32'(fsm_state),              32'(m_mode));
`ifdef PC_SEQ_REDIRECT_CNT_EN
        check({tag, ".cnt"},      32'(redirect_cnt),           32'(m_cnt));
`endif
    endtask

    task automatic drive(input bit e, input logic [31:0] ev, input bit b, input logic [31:0] bt,
                         input bit st, input bit h, input bit rdy);
        exc_valid   = e;
        exc_vector  = ev;
        br_valid    = b;
        br_target   = bt;
        stall       = st;
        halt        = h;
        fetch_ready = rdy;
    endtask

    // Apply current inputs for one edge, then compare just after it.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all("boot");

        // Sequential fetch after boot: 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) step("seq");

        // Hold at 0x10 while not ready, then advance.
        drive(0, 0, 1, 32'h10, 0, 0, 1);
        step("br10");
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("hold");
        check("hold_pc", pc, 32'h10);
        drive(0, 0, 0, 0, 0, 0, 1);
        step("adv14");
        check("adv_pc", pc, 32'h14);

        // Exception wins over a simultaneous branch.
        drive(1, 32'h18, 1, 32'h100, 0, 0, 1);
        step("exc");
        check("exc_pc", pc, 32'h18);
        drive(0, 0, 0, 0, 0, 0, 1);
        step("exc_after");

        // Redirect under stall, misaligned target, then stall holds.
        drive(0, 0, 1, 32'h203, 1, 0, 1);
        step("stall_br");
        check("mis_pc", pc, 32'h200);
        drive(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step("stall");
        drive(0, 0, 0, 0, 0, 0, 1);
        step("unstall");

        // Halt with a completing handshake, then leave HALTED by branch.
        drive(0, 0, 1, 32'h40, 0, 0, 1);
        step("br40");
        drive(0, 0, 0, 0, 0, 1, 1);
        step("halt");
        check("halt_pc", pc, 32'h44);
        step("halted");
        drive(0, 0, 1, 32'h80, 0, 1, 1);
        step("wake");
        check("wake_pc", pc, 32'h80);
        drive(0, 0, 0, 0, 0, 0, 1);
        step("run80");

        // Wrap from the top of the address space.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
        step("brtop");
        drive(0, 0, 0, 0, 0, 0, 1);
        step("wrap");
        check("wrap_pc", pc, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(15) == 0, $urandom, $urandom_range(7) == 0, $urandom,
                  $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0);
            step("rand");
        end

        // Asynchronous reset in the middle of a cycle.
        drive(0, 0, 0, 0, 0, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
